// File: rtl/fault_retry_pkg.sv
// ============================================================================
// Module : fault_retry_pkg
// Shared state encodings, timer width and default timing for the fault
// retry sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fault_retry_pkg;

    localparam int unsigned c_STATE_W = 5;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE    = 5'b00001;
    localparam state_t c_ST_HOLDOFF = 5'b00010;
    localparam state_t c_ST_PULSE   = 5'b00100;
    localparam state_t c_ST_ACK     = 5'b01000;
    localparam state_t c_ST_LOCKOUT = 5'b10000;

    localparam int unsigned c_TIMER_W = 29;

    localparam int unsigned c_DEF_HOLDOFF_CYCLES  = 50_000_000;
    localparam int unsigned c_DEF_PULSE_CYCLES    = 50;
    localparam int unsigned c_DEF_ACK_CYCLES      = 1000;
    localparam int unsigned c_DEF_MAX_RETRY       = 3;
    localparam int unsigned c_DEF_CLEAR_CYCLES    = 500_000_000;
    localparam int unsigned c_DEF_DEBOUNCE_CYCLES = 500_000;

endpackage

`default_nettype wire

// File: rtl/fault_retry_ctrl_debounce.sv
// ============================================================================
// Module : debounce
// Level debouncer: dout follows din once din has differed from it for
// DEBOUNCE_CYCLES consecutive cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce
    import fault_retry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic CLK_50M,
    input  logic Rst_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned         c_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dout;

    // Any return to the current level restarts the stability count.
    always_ff @(posedge CLK_50M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt  <= '0;
            r_dout <= 1'b0;
        end else if (din == r_dout) begin
            r_cnt  <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt  <= '0;
            r_dout <= din;
        end else begin
            r_cnt  <= r_cnt + c_CNT_W'(1);
        end
    end

    assign dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/fault_retry_ctrl.sv
// ============================================================================
// Module : fault_retry_ctrl
// Fault-recovery sequencer: hold-off, ResetD re-arm pulse, ack wait, bounded
// retries and a lockout cleared only by a debounced manual reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fault_retry_ctrl
    import fault_retry_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYCLES  = c_DEF_HOLDOFF_CYCLES,
    parameter int unsigned PULSE_CYCLES    = c_DEF_PULSE_CYCLES,
    parameter int unsigned ACK_CYCLES      = c_DEF_ACK_CYCLES,
    parameter int unsigned MAX_RETRY       = c_DEF_MAX_RETRY,
    parameter int unsigned CLEAR_CYCLES    = c_DEF_CLEAR_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic       CLK_50M,
    input  logic       Rst_n,
    input  logic       PWMEN,
    input  logic       ManualRst,
    output logic       ResetD,
    output logic       Lockout,
    output logic       FaultActive,
    output logic [2:0] RetryCnt
);

    localparam logic [c_TIMER_W-1:0] c_HOLD_LAST  = c_TIMER_W'(HOLDOFF_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_PULSE_LAST = c_TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_ACK_LAST   = c_TIMER_W'(ACK_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_CLEAR_LAST = c_TIMER_W'(CLEAR_CYCLES - 1);
    localparam logic [2:0]           c_MAX_RETRY  = 3'(MAX_RETRY);

    logic [1:0]           r_pwm_sync;
    logic [1:0]           r_man_sync;
    logic                 r_man_prev;
    logic                 w_pwm_s;
    logic                 w_man_s;
    logic                 w_man_rise;

    state_t               r_state;
    state_t               w_next;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_TIMER_W-1:0] w_timer_next;
    logic [2:0]           r_cnt;
    logic [2:0]           w_cnt_next;
    logic                 r_reset_d;
    logic                 r_lockout;
    logic                 r_fault_active;

    always_ff @(posedge CLK_50M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pwm_sync <= 2'b11;
            r_man_sync <= 2'b00;
            r_man_prev <= 1'b0;
        end else begin
            r_pwm_sync <= {r_pwm_sync[0], PWMEN};
            r_man_sync <= {r_man_sync[0], ManualRst};
            r_man_prev <= w_man_s;
        end
    end

    assign w_pwm_s = r_pwm_sync[1];

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK_50M (CLK_50M),
        .Rst_n   (Rst_n),
        .din     (r_man_sync[1]),
        .dout    (w_man_s)
    );

    assign w_man_rise = w_man_s & ~r_man_prev;

    always_comb begin
        w_next       = r_state;
        w_timer_next = r_timer + c_TIMER_W'(1);
        w_cnt_next   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_man_rise) begin
                    w_next     = c_ST_PULSE;
                    w_cnt_next = 3'd0;
                end else if (!w_pwm_s) begin
                    w_next = (r_cnt == c_MAX_RETRY) ? c_ST_LOCKOUT : c_ST_HOLDOFF;
                end else if (r_timer == c_CLEAR_LAST) begin
                    w_cnt_next   = 3'd0;
                    w_timer_next = '0;
                end
            end
            c_ST_HOLDOFF: begin
                if (w_man_rise) begin
                    w_next     = c_ST_PULSE;
                    w_cnt_next = 3'd0;
                end else if (r_timer == c_HOLD_LAST) begin
                    w_next = c_ST_PULSE;
                    if (r_cnt != c_MAX_RETRY) begin
                        w_cnt_next = r_cnt + 3'd1;
                    end
                end
            end
            c_ST_PULSE: begin
                if (r_timer == c_PULSE_LAST) begin
                    w_next = c_ST_ACK;
                end
            end
            c_ST_ACK: begin
                // An unanswered pulse is a failed retry: try again while retries remain.
                if (w_man_rise) begin
                    w_next     = c_ST_PULSE;
                    w_cnt_next = 3'd0;
                end else if (w_pwm_s) begin
                    w_next = c_ST_IDLE;
                end else if (r_timer == c_ACK_LAST) begin
                    w_next = (r_cnt == c_MAX_RETRY) ? c_ST_LOCKOUT : c_ST_HOLDOFF;
                end
            end
            c_ST_LOCKOUT: begin
                w_timer_next = '0;
                if (w_man_rise) begin
                    w_next     = c_ST_PULSE;
                    w_cnt_next = 3'd0;
                end
            end
            default: begin
                w_next     = c_ST_IDLE;
                w_cnt_next = 3'd0;
            end
        endcase
        if (w_next != r_state) begin
            w_timer_next = '0;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK_50M or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state        <= c_ST_IDLE;
            r_timer        <= '0;
            r_cnt          <= 3'd0;
            r_reset_d      <= 1'b0;
            r_lockout      <= 1'b0;
            r_fault_active <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_timer        <= w_timer_next;
            r_cnt          <= w_cnt_next;
            r_reset_d      <= (w_next == c_ST_PULSE);
            r_lockout      <= (w_next == c_ST_LOCKOUT);
            r_fault_active <= (w_next != c_ST_IDLE);
        end
    end

    assign ResetD      = r_reset_d;
    assign Lockout     = r_lockout;
    assign FaultActive = r_fault_active;
    assign RetryCnt    = r_cnt;

endmodule

`default_nettype wire
